// File: rtl/pipeline_stage_registers.sv
// Shared pipeline-register types, opcode constants and ALU-op helper for the RISCAT RV32I core.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_stage_registers;

    // Fetch -> decode pipeline register
    typedef struct packed {
        logic [31:0] fetched_inst;
        logic [31:0] pc;
    } IF_ID;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_t;

    // Decode -> execute pipeline register
    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        alu_op_t     alu_op;
        logic [2:0]  funct3;
        logic        alu_src_imm;
        logic        alu_src_pc;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
    } ID_EX;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    // Map funct3 to an ALU op; alt selects SUB (funct3=000) or SRA (funct3=101).
    function automatic alu_op_t alu_from_funct3(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 register file, 2 combinational read ports, 1 posedge write port, x0 hardwired to 0.
// Latency: reads 0 cycles (write-through bypass from the write port); writes land at posedge.
// Backpressure: none; writes always accepted except during reset.
// Ports: clk/rst; i_ra1/i_ra2 read addresses -> o_rd1/o_rd2; i_we/i_wa/i_wd write port.
module register_file #(
    parameter int RESET_REGS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2,
    input  logic        i_we,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd
);

    logic [31:0] r_regs [32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if (RESET_REGS != 0) begin
                for (int i = 0; i < 32; i++) begin
                    r_regs[i] <= '0;
                end
            end
        end else if (i_we && (i_wa != 5'd0)) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    // Bypass lets a reader see a value written back in the same cycle.
    always_comb begin
        if (i_ra1 == 5'd0)                   o_rd1 = '0;
        else if (i_we && (i_wa == i_ra1))    o_rd1 = i_wd;
        else                                 o_rd1 = r_regs[i_ra1];

        if (i_ra2 == 5'd0)                   o_rd2 = '0;
        else if (i_we && (i_wa == i_ra2))    o_rd2 = i_wd;
        else                                 o_rd2 = r_regs[i_ra2];
    end

endmodule

// File: rtl/decode_unit.sv
// RV32I decode stage: decodes IF_ID, reads operands, registers ID_EX; detects load-use hazards.
// Latency: 1 cycle IF_ID -> ID_EX; load_use_stall is combinational.
// Backpressure: ex_hold freezes ID_EX; load_use_stall tells fetch to hold; flush inserts a bubble.
// Ports: clk/reset; if_id_reg + if_valid in; flush/ex_hold control; wb_we/wb_rd/wb_data writeback;
//        id_ex_reg out; load_use_stall out.
module decode_unit
    import pipeline_stage_registers::*;
#(
    parameter int RESET_REGS = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  IF_ID        if_id_reg,
    input  logic        if_valid,
    input  logic        flush,
    input  logic        ex_hold,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output ID_EX        id_ex_reg,
    output logic        load_use_stall
);

    ID_EX        r_id_ex;
    ID_EX        w_dec;
    logic [31:0] w_inst;
    logic [6:0]  w_op;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic        w_illegal;
    logic        w_uses_rs1;
    logic        w_uses_rs2;

    assign w_inst = if_id_reg.fetched_inst;
    assign w_op   = w_inst[6:0];
    assign w_f3   = w_inst[14:12];
    assign w_f7   = w_inst[31:25];
    assign w_rs1  = w_inst[19:15];
    assign w_rs2  = w_inst[24:20];
    assign w_rd   = w_inst[11:7];

    assign w_imm_i = {{20{w_inst[31]}}, w_inst[31:20]};
    assign w_imm_s = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
    assign w_imm_b = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
    assign w_imm_u = {w_inst[31:12], 12'b0};
    assign w_imm_j = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};

    register_file #(.RESET_REGS(RESET_REGS)) u_regfile (
        .clk   (clk),
        .rst   (reset),
        .i_ra1 (w_rs1),
        .i_ra2 (w_rs2),
        .o_rd1 (w_rs1_val),
        .o_rd2 (w_rs2_val),
        .i_we  (wb_we),
        .i_wa  (wb_rd),
        .i_wd  (wb_data)
    );

    always_comb begin
        w_dec         = '0;
        w_illegal     = 1'b0;
        w_dec.valid   = if_valid;
        w_dec.pc      = if_id_reg.pc;
        w_dec.rs1     = w_rs1;
        w_dec.rs2     = w_rs2;
        w_dec.rd      = w_rd;
        w_dec.rs1_val = w_rs1_val;
        w_dec.rs2_val = w_rs2_val;
        w_dec.funct3  = w_f3;
        w_dec.alu_op  = ALU_ADD;

        case (w_op)
            OP_LUI: begin
                w_dec.imm         = w_imm_u;
                w_dec.alu_op      = ALU_PASS_B;
                w_dec.alu_src_imm = 1'b1;
                w_dec.reg_write   = 1'b1;
            end
            OP_AUIPC: begin
                w_dec.imm         = w_imm_u;
                w_dec.alu_src_imm = 1'b1;
                w_dec.alu_src_pc  = 1'b1;
                w_dec.reg_write   = 1'b1;
            end
            OP_JAL: begin
                w_dec.imm         = w_imm_j;
                w_dec.alu_src_imm = 1'b1;
                w_dec.alu_src_pc  = 1'b1;
                w_dec.reg_write   = 1'b1;
                w_dec.jump        = 1'b1;
            end
            OP_JALR: begin
                w_dec.imm         = w_imm_i;
                w_dec.alu_src_imm = 1'b1;
                w_dec.reg_write   = 1'b1;
                w_dec.jump        = 1'b1;
            end
            OP_BRANCH: begin
                // ALU forms the target pc+imm; execute compares rs1/rs2 using funct3.
                w_dec.imm         = w_imm_b;
                w_dec.alu_src_imm = 1'b1;
                w_dec.alu_src_pc  = 1'b1;
                w_dec.branch      = 1'b1;
            end
            OP_LOAD: begin
                w_dec.imm         = w_imm_i;
                w_dec.alu_src_imm = 1'b1;
                w_dec.reg_write   = 1'b1;
                w_dec.mem_read    = 1'b1;
            end
            OP_STORE: begin
                w_dec.imm         = w_imm_s;
                w_dec.alu_src_imm = 1'b1;
                w_dec.mem_write   = 1'b1;
            end
            OP_IMM: begin
                w_dec.imm         = w_imm_i;
                w_dec.alu_src_imm = 1'b1;
                w_dec.reg_write   = 1'b1;
                // Only shift immediates carry a funct7 field; ADDI never means SUB.
                w_dec.alu_op      = alu_from_funct3(w_f3, (w_f3 == 3'b101) && w_f7[5]);
                if (w_f3 == 3'b001 && w_f7 != 7'b0000000) begin
                    w_illegal = 1'b1;
                end
                if (w_f3 == 3'b101 && w_f7 != 7'b0000000 && w_f7 != 7'b0100000) begin
                    w_illegal = 1'b1;
                end
            end
            OP_OP: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_op    = alu_from_funct3(w_f3, w_f7[5]);
                if (w_f7 == 7'b0100000) begin
                    if (w_f3 != 3'b000 && w_f3 != 3'b101) begin
                        w_illegal = 1'b1;
                    end
                end else if (w_f7 != 7'b0000000) begin
                    w_illegal = 1'b1;
                end
            end
            OP_MISC_MEM, OP_SYSTEM: begin
                // Treated as a valid NOP: no control bits set.
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase

        if (w_illegal) begin
            w_dec.imm         = '0;
            w_dec.alu_op      = ALU_ADD;
            w_dec.alu_src_imm = 1'b0;
            w_dec.alu_src_pc  = 1'b0;
            w_dec.reg_write   = 1'b0;
            w_dec.mem_read    = 1'b0;
            w_dec.mem_write   = 1'b0;
            w_dec.branch      = 1'b0;
            w_dec.jump        = 1'b0;
        end
        w_dec.illegal = w_illegal;

        if (w_rd == 5'd0) begin
            w_dec.reg_write = 1'b0;
        end
    end

    // U and J formats carry immediate bits where rs1/rs2 would be.
    assign w_uses_rs1 = !((w_op == OP_LUI) || (w_op == OP_AUIPC) || (w_op == OP_JAL));
    assign w_uses_rs2 = (w_op == OP_OP) || (w_op == OP_STORE) || (w_op == OP_BRANCH);

    assign load_use_stall = if_valid && r_id_ex.valid && r_id_ex.mem_read &&
                            (r_id_ex.rd != 5'd0) &&
                            ((w_uses_rs1 && (r_id_ex.rd == w_rs1)) ||
                             (w_uses_rs2 && (r_id_ex.rd == w_rs2))) &&
                            !flush && !ex_hold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_id_ex <= '0;
        end else if (flush) begin
            r_id_ex <= '0;
        end else if (ex_hold) begin
            r_id_ex <= r_id_ex;
        end else if (load_use_stall) begin
            r_id_ex <= '0;
        end else begin
            r_id_ex <= w_dec;
        end
    end

    assign id_ex_reg = r_id_ex;

endmodule

// File: tb/tb_decode_unit.sv
// Self-checking bench for decode_unit: decode vector table plus bypass, load-use, priority, reset sequences.
// Latency: checks ID_EX one cycle after an instruction is presented.
// Backpressure: exercises flush, ex_hold and load-use stall.
module tb_decode_unit;
    import pipeline_stage_registers::*;

    logic        clk = 1'b0;
    logic        reset;
    IF_ID        if_id_reg;
    logic        if_valid;
    logic        flush;
    logic        ex_hold;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    ID_EX        id_ex_reg;
    logic        load_use_stall;

    int n_checks = 0;
    int n_err    = 0;

    decode_unit dut (
        .clk            (clk),
        .reset          (reset),
        .if_id_reg      (if_id_reg),
        .if_valid       (if_valid),
        .flush          (flush),
        .ex_hold        (ex_hold),
        .wb_we          (wb_we),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .id_ex_reg      (id_ex_reg),
        .load_use_stall (load_use_stall)
    );

    always #5 clk = ~clk;

    // ctl = {alu_src_imm, alu_src_pc, reg_write, mem_read, mem_write, branch, jump}
    typedef struct {
        logic [31:0] inst;
        logic        vld;
        logic [4:0]  rd;
        logic [31:0] imm;
        alu_op_t     alu;
        logic [2:0]  f3;
        logic [6:0]  ctl;
        logic        ill;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic v);
        if_id_reg.fetched_inst = inst;
        if_id_reg.pc           = pc;
        if_valid               = v;
    endtask

    initial begin
        vecs[0]  = '{32'h00500093, 1'b1, 5'd1,  32'd5,        ALU_ADD,    3'd0, 7'b1010000, 1'b0};
        vecs[1]  = '{32'hFE000CE3, 1'b1, 5'd25, 32'hFFFFFFF8, ALU_ADD,    3'd0, 7'b1100010, 1'b0};
        vecs[2]  = '{32'h12345137, 1'b1, 5'd2,  32'h12345000, ALU_PASS_B, 3'd5, 7'b1010000, 1'b0};
        vecs[3]  = '{32'h00001197, 1'b1, 5'd3,  32'h00001000, ALU_ADD,    3'd1, 7'b1110000, 1'b0};
        vecs[4]  = '{32'h008000EF, 1'b1, 5'd1,  32'd8,        ALU_ADD,    3'd0, 7'b1110001, 1'b0};
        vecs[5]  = '{32'h00008067, 1'b1, 5'd0,  32'd0,        ALU_ADD,    3'd0, 7'b1000001, 1'b0};
        vecs[6]  = '{32'h00002283, 1'b1, 5'd5,  32'd0,        ALU_ADD,    3'd2, 7'b1011000, 1'b0};
        vecs[7]  = '{32'h0020A623, 1'b1, 5'd12, 32'd12,       ALU_ADD,    3'd2, 7'b1000100, 1'b0};
        vecs[8]  = '{32'h402083B3, 1'b1, 5'd7,  32'd0,        ALU_SUB,    3'd0, 7'b0010000, 1'b0};
        vecs[9]  = '{32'h4030D413, 1'b1, 5'd8,  32'h00000403, ALU_SRA,    3'd5, 7'b1010000, 1'b0};
        vecs[10] = '{32'h022081B3, 1'b1, 5'd3,  32'd0,        ALU_ADD,    3'd0, 7'b0000000, 1'b1};
        vecs[11] = '{32'hFFFFFFFF, 1'b1, 5'd31, 32'd0,        ALU_ADD,    3'd7, 7'b0000000, 1'b1};
        vecs[12] = '{32'h0FF0000F, 1'b1, 5'd0,  32'd0,        ALU_ADD,    3'd0, 7'b0000000, 1'b0};
        vecs[13] = '{32'h00000073, 1'b1, 5'd0,  32'd0,        ALU_ADD,    3'd0, 7'b0000000, 1'b0};
        vecs[14] = '{32'h0020C4B3, 1'b1, 5'd9,  32'd0,        ALU_XOR,    3'd4, 7'b0010000, 1'b0};
        vecs[15] = '{32'h00500093, 1'b0, 5'd1,  32'd5,        ALU_ADD,    3'd0, 7'b1010000, 1'b0};

        reset   = 1'b1;
        flush   = 1'b0;
        ex_hold = 1'b0;
        wb_we   = 1'b0;
        wb_rd   = '0;
        wb_data = '0;
        drive(32'h0, 32'h0, 1'b0);
        #2;
        chk("reset id_ex zero", 64'(|id_ex_reg), 64'd0);
        chk("reset stall", 64'(load_use_stall), 64'd0);
        step();
        reset = 1'b0;

        // Decode table: one instruction per cycle, checked the cycle after it is presented.
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].inst, 32'h10 + 32'(i) * 4, vecs[i].vld);
            step();
            chk($sformatf("vec%0d ctl", i),
                64'({id_ex_reg.valid, id_ex_reg.illegal, 4'(id_ex_reg.alu_op), id_ex_reg.funct3,
                     id_ex_reg.alu_src_imm, id_ex_reg.alu_src_pc, id_ex_reg.reg_write,
                     id_ex_reg.mem_read, id_ex_reg.mem_write, id_ex_reg.branch, id_ex_reg.jump}),
                64'({vecs[i].vld, vecs[i].ill, 4'(vecs[i].alu), vecs[i].f3, vecs[i].ctl}));
            chk($sformatf("vec%0d imm", i), 64'(id_ex_reg.imm), 64'(vecs[i].imm));
            chk($sformatf("vec%0d rd", i), 64'(id_ex_reg.rd), 64'(vecs[i].rd));
            chk($sformatf("vec%0d pc", i), 64'(id_ex_reg.pc), 64'(32'h10 + 32'(i) * 4));
        end

        // Write-through bypass to x3 while decoding add x4,x3,x3.
        drive(32'h00318233, 32'h100, 1'b1);
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
        step();
        chk("bypass rs1_val", 64'(id_ex_reg.rs1_val), 64'hDEADBEEF);
        chk("bypass rs2_val", 64'(id_ex_reg.rs2_val), 64'hDEADBEEF);
        // Write to x0 must not bypass nor stick.
        drive(32'h00000233, 32'h104, 1'b1);
        wb_rd = 5'd0; wb_data = 32'h1234;
        step();
        chk("x0 bypass", 64'(id_ex_reg.rs1_val), 64'd0);
        wb_we = 1'b0;
        step();
        chk("x0 stored", 64'(id_ex_reg.rs1_val), 64'd0);
        drive(32'h00018233, 32'h108, 1'b1);
        step();
        chk("x3 stored", 64'(id_ex_reg.rs1_val), 64'hDEADBEEF);
        // Put 0x55 in x1 for the reset test later.
        drive(32'h00108233, 32'h10C, 1'b1);
        wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h55;
        step();
        wb_we = 1'b0;
        step();
        chk("x1 stored", 64'(id_ex_reg.rs1_val), 64'h55);

        // Load-use: lw x5 then add x6,x5,x0.
        drive(32'h00002283, 32'h200, 1'b1);
        step();
        chk("lu lw in idex", 64'({id_ex_reg.valid, id_ex_reg.mem_read, id_ex_reg.rd}), 64'({1'b1, 1'b1, 5'd5}));
        drive(32'h00028333, 32'h204, 1'b1);
        #1;
        chk("lu stall high", 64'(load_use_stall), 64'd1);
        step();
        chk("lu bubble", 64'(id_ex_reg.valid), 64'd0);
        chk("lu stall low", 64'(load_use_stall), 64'd0);
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h0000CAFE;
        step();
        wb_we = 1'b0;
        chk("lu consumer", 64'({id_ex_reg.valid, id_ex_reg.rs1, id_ex_reg.rd}), 64'({1'b1, 5'd5, 5'd6}));
        chk("lu consumer val", 64'(id_ex_reg.rs1_val), 64'h0000CAFE);

        // Priority: flush + ex_hold over a pending stall.
        drive(32'h00002283, 32'h300, 1'b1);
        step();
        drive(32'h00028333, 32'h304, 1'b1);
        #1;
        chk("pri stall pre", 64'(load_use_stall), 64'd1);
        flush = 1'b1; ex_hold = 1'b1;
        #1;
        chk("pri stall masked", 64'(load_use_stall), 64'd0);
        step();
        chk("pri flush bubble", 64'(id_ex_reg.valid), 64'd0);
        flush = 1'b0; ex_hold = 1'b0;
        drive(32'h00500093, 32'h10, 1'b1);
        step();
        ex_hold = 1'b1;
        drive(32'h0020C4B3, 32'h80, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("hold%0d fields", k), 64'({id_ex_reg.valid, id_ex_reg.rd, id_ex_reg.imm}),
                64'({1'b1, 5'd1, 32'd5}));
            chk($sformatf("hold%0d pc", k), 64'(id_ex_reg.pc), 64'h10);
        end
        ex_hold = 1'b0;
        step();
        chk("hold release", 64'({id_ex_reg.rd, id_ex_reg.pc}), 64'({5'd9, 32'h80}));

        // Async reset in the middle of a stall.
        drive(32'h00002283, 32'h400, 1'b1);
        step();
        drive(32'h00028333, 32'h404, 1'b1);
        #1;
        chk("rst stall pre", 64'(load_use_stall), 64'd1);
        reset = 1'b1;
        #1;
        chk("rst async id_ex", 64'(|id_ex_reg), 64'd0);
        chk("rst async stall", 64'(load_use_stall), 64'd0);
        #2;
        reset = 1'b0;
        step();
        drive(32'h00508233, 32'h408, 1'b1);
        step();
        chk("rst x1 cleared", 64'(id_ex_reg.rs1_val), 64'd0);
        chk("rst x5 cleared", 64'(id_ex_reg.rs2_val), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/decode_unit.md
# decode_unit

Second pipeline stage of the RISCAT RV32I core. Consumes the `IF_ID` register produced by the fetch stage, decodes the instruction, reads operands from an internal 32x32 register file, and registers the result into `ID_EX` for the execute stage. It also detects load-use hazards, signals fetch to hold, and honours flush and hold requests from downstream.

## Interface

Parameters:
- `RESET_REGS`, default 1: when 1, reset clears x1..x31 to 0.

Ports:
- `clk`, in, 1: rising-edge clock.
- `reset`, in, 1: asynchronous, active-high reset. This is already decided.
- `if_id_reg`, in, `IF_ID`: `fetched_inst[31:0]` and `pc[31:0]`.
- `if_valid`, in, 1: `if_id_reg` holds a real instruction.
- `flush`, in, 1: redirect from execute; kill the instruction in decode.
- `ex_hold`, in, 1: execute cannot accept; freeze `ID_EX`.
- `wb_we`, in, 1: writeback write enable.
- `wb_rd`, in, 5: writeback destination register.
- `wb_data`, in, 32: writeback data.
- `id_ex_reg`, out, `ID_EX`: registered decode result.
- `load_use_stall`, out, 1: combinational; fetch must hold its PC and `IF_ID`.

## Operation

- Decoded formats: R, I, S, B, U, J.
- Supported opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP. FENCE and SYSTEM decode as NOP with valid=1.
- `ID_EX` fields:
  - `valid`, `illegal`, `pc`
  - `rs1`, `rs2`, `rd`
  - `rs1_val`, `rs2_val`, `imm[31:0]`
  - `alu_op`, `funct3`
  - `alu_src_imm`, `alu_src_pc`
  - `reg_write`, `mem_read`, `mem_write`, `branch`, `jump`
- Immediates are sign-extended from bit 31. U-type is `{inst[31:12], 12'b0}`. B-type and J-type have bit 0 = 0.
- `alu_op` values: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B.
  - LUI uses PASS_B.
  - AUIPC, JAL, JALR, loads and stores use ADD.
  - SUB applies only to OP with funct7[5]=1. SRA applies when funct7[5]=1.
- Illegal opcode or funct7 produces `illegal`=1 and `valid`=1, with `reg_write`, `mem_read`, `mem_write`, `branch` and `jump` all forced to 0.
- `reg_write` is forced to 0 when rd=0.
- Register file:
  - Two combinational read ports and one write port at posedge.
  - Writes to x0 are ignored; x0 always reads 0.
  - Write-through bypass: if `wb_we` and `wb_rd`==rs≠0, the read returns `wb_data`.
- Load-use detection: `load_use_stall`=1 when all of the following hold:
  - `if_valid`
  - `id_ex_reg.valid` and `id_ex_reg.mem_read`
  - `id_ex_reg.rd`≠0
  - `id_ex_reg.rd` matches a source register the current format actually uses (rs1 for all except U and J; rs2 for R, S and B only).
- `load_use_stall` is forced to 0 while `flush` or `ex_hold` is asserted.
- `ID_EX` update priority at posedge, highest first:
  1. `reset`: all fields 0.
  2. `flush`: bubble (`valid`=0, all control bits 0).
  3. `ex_hold`: retain every field unchanged.
  4. `load_use_stall`: bubble.
  5. Otherwise: load the decode of `if_id_reg`, with `valid`=`if_valid`.
- Register-file writes proceed regardless of `flush`, `ex_hold` and stall. Only `reset` blocks them.

## Timing

- Latency: an instruction present in `IF_ID` at edge N appears in `ID_EX` after edge N+1.
- Throughput: one instruction per cycle with no hazards.
- A load-use stall costs exactly 1 bubble. On the next cycle the load has left `ID_EX`, so the stall deasserts and the consumer reads its operand through the bypass or the regfile.
- Reset is asynchronous:
  - `id_ex_reg` goes to all zeros immediately.
  - `load_use_stall` goes to 0.
  - Regfile goes to 0 when `RESET_REGS`=1.
- Reset asserted mid-stall: the bubble is discarded and no state is retained.
- Simultaneous `flush` and `load_use_stall`: `flush` wins and the stall output is 0.
- Simultaneous `wb_we` to rs and decode of a reader: the reader sees the new value in the same cycle.

## Structure

- Add an `ID_EX` struct and an `alu_op_t` enum to `pipeline_stage_registers.sv`, next to `IF_ID`.
- Add opcode localparams (`OP_LUI` = 7'b0110111, and the rest) to the same shared package.
- Sub-module `register_file`: 2R1W with bypass and x0 hardwired to 0.
- Decode, immediate generation and hazard logic stay in `decode_unit`.

## Test plan

- **Basic decode.** Apply 0x00500093 (addi x1,x0,5) at pc 0x10 with `if_valid`=1. Next cycle: `valid`=1, `rd`=1, `imm`=5, `alu_op`=ADD, `alu_src_imm`=1, `reg_write`=1, `pc`=0x10.
- **B-type immediate.** Apply 0xFE000CE3 (beq x0,x0,-8). Result: `imm`=0xFFFFFFF8, `branch`=1, `reg_write`=0, `funct3`=0.
- **Write-through bypass.** Drive `wb_we`=1, `wb_rd`=3, `wb_data`=0xDEADBEEF in the same cycle as decoding 0x00318233 (add x4,x3,x3). Result: `rs1_val`=`rs2_val`=0xDEADBEEF. Separately, `wb_rd`=0 with data 0x1234 leaves x0 reading 0.
- **Load-use stall.** Apply 0x00002283 (lw x5,0(x0)) followed by 0x00028333 (add x6,x5,x0). `load_use_stall`=1 for exactly one cycle, `ID_EX` carries one bubble, then the add appears with `rs1`=5.
- **Priority.** Assert `flush` and `ex_hold` together while a stall condition exists. Next `ID_EX` is a bubble and `load_use_stall`=0. Then with `ex_hold` alone, `ID_EX` holds its contents for 3 cycles.
- **Async reset.** Assert `reset` between clock edges while `ID_EX` is valid. Outputs go to zero without waiting for an edge, and after release x1..x31 read 0.
